// File: rtl/ddr_pixel_writeback_pkg.sv
// Definitions shared by the DDR<->BRAM pixel stages: writeback FSM encoding and
// the order in which the nine direction values are packed into a stream beat.
package ddr_pixel_writeback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } wb_state_t;

    localparam int NUM_DIRS = 9;

    // Direction index doubles as the slot number within a packed pixel
    localparam int DIR_N    = 0;
    localparam int DIR_NULL = 1;
    localparam int DIR_NE   = 2;
    localparam int DIR_E    = 3;
    localparam int DIR_SE   = 4;
    localparam int DIR_S    = 5;
    localparam int DIR_SW   = 6;
    localparam int DIR_W    = 7;
    localparam int DIR_NW   = 8;

    function automatic int dir_lsb(input int dir, input int data_width);
        return dir * data_width;
    endfunction

endpackage

// File: rtl/ddr_pixel_writeback_skid.sv
// Two-entry valid/ready buffer holding packed pixels returned from BRAM until
// the AXI-Stream sink accepts them; the head entry stays put while stalled.
module pixel_skid_fifo #(
    parameter int WIDTH = 144
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_vld,
    output logic             o_in_rdy,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_vld,
    input  logic             i_out_rdy,
    output logic [WIDTH-1:0] o_out_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_out_vld  = (r_count != 2'd0);
    assign o_in_rdy   = (r_count != 2'd2) || i_out_rdy;
    assign w_push     = i_in_vld && o_in_rdy;
    assign w_pop      = o_out_vld && i_out_rdy;
    assign o_out_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_pixel_writeback.sv
// Streams one finished result chunk out of the nine direction BRAMs as packed
// 144-bit AXI-Stream beats, one pixel per beat, then pulses writeback_done.
module ddr_pixel_writeback
    import ddr_pixel_writeback_pkg::*;
#(
    parameter int DATA_WIDTH             = 16,
    parameter int DEPTH                  = 2500,
    parameter int ADDRESS_WIDTH          = 12,
    parameter int C_M00_AXIS_TDATA_WIDTH = 144
) (
    input  logic                                m00_axis_aclk,
    input  logic                                m00_axis_aresetn,
    input  logic                                chunk_done,
    output logic                                ren,
    output logic [ADDRESS_WIDTH-1:0]            read_addr,
    input  logic [DATA_WIDTH-1:0]               n_q,
    input  logic [DATA_WIDTH-1:0]               null_q,
    input  logic [DATA_WIDTH-1:0]               ne_q,
    input  logic [DATA_WIDTH-1:0]               e_q,
    input  logic [DATA_WIDTH-1:0]               se_q,
    input  logic [DATA_WIDTH-1:0]               s_q,
    input  logic [DATA_WIDTH-1:0]               sw_q,
    input  logic [DATA_WIDTH-1:0]               w_q,
    input  logic [DATA_WIDTH-1:0]               nw_q,
    output logic                                m00_axis_tvalid,
    input  logic                                m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    output logic                                busy,
    output logic                                writeback_done
);

    localparam int              CW       = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(DEPTH - 1);

    wb_state_t                         r_state;
    wb_state_t                         w_state_nxt;
    logic [CW-1:0]                     r_rd_cnt;
    logic [CW-1:0]                     r_beat_cnt;
    logic [ADDRESS_WIDTH-1:0]          r_last_addr;
    logic                              r_rd_vld;
    logic                              w_pop;
    logic                              w_fifo_vld;
    logic                              w_in_rdy;
    logic [1:0]                        w_occ;
    logic [2:0]                        w_load;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] w_pixel;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] w_fifo_data;

    always_comb begin
        w_pixel = '0;
        w_pixel[dir_lsb(DIR_N,    DATA_WIDTH) +: DATA_WIDTH] = n_q;
        w_pixel[dir_lsb(DIR_NULL, DATA_WIDTH) +: DATA_WIDTH] = null_q;
        w_pixel[dir_lsb(DIR_NE,   DATA_WIDTH) +: DATA_WIDTH] = ne_q;
        w_pixel[dir_lsb(DIR_E,    DATA_WIDTH) +: DATA_WIDTH] = e_q;
        w_pixel[dir_lsb(DIR_SE,   DATA_WIDTH) +: DATA_WIDTH] = se_q;
        w_pixel[dir_lsb(DIR_S,    DATA_WIDTH) +: DATA_WIDTH] = s_q;
        w_pixel[dir_lsb(DIR_SW,   DATA_WIDTH) +: DATA_WIDTH] = sw_q;
        w_pixel[dir_lsb(DIR_W,    DATA_WIDTH) +: DATA_WIDTH] = w_q;
        w_pixel[dir_lsb(DIR_NW,   DATA_WIDTH) +: DATA_WIDTH] = nw_q;
    end

    pixel_skid_fifo #(
        .WIDTH (C_M00_AXIS_TDATA_WIDTH)
    ) u_skid (
        .i_clk      (m00_axis_aclk),
        .i_rst_n    (m00_axis_aresetn),
        .i_in_vld   (r_rd_vld),
        .o_in_rdy   (w_in_rdy),
        .i_in_data  (w_pixel),
        .o_out_vld  (w_fifo_vld),
        .i_out_rdy  (m00_axis_tready),
        .o_out_data (w_fifo_data),
        .o_count    (w_occ)
    );

    // A beat leaving this cycle frees its slot, so back-to-back reads keep one beat per clock
    assign w_pop  = w_fifo_vld && m00_axis_tready;
    assign w_load = 3'(w_occ) + 3'(r_rd_vld) - 3'(w_pop);
    assign ren    = (r_state == ST_STREAM) && (w_load < 3'd2);

    assign read_addr       = ren ? r_rd_cnt[ADDRESS_WIDTH-1:0] : r_last_addr;
    assign m00_axis_tvalid = w_fifo_vld;
    assign m00_axis_tdata  = w_fifo_data;
    assign m00_axis_tlast  = w_fifo_vld && (r_beat_cnt == LAST_IDX);
    assign m00_axis_tstrb  = '1;

    always_comb begin
        w_state_nxt    = r_state;
        busy           = 1'b0;
        writeback_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (chunk_done) w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                busy = 1'b1;
                if (ren && (r_rd_cnt == LAST_IDX)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_pop && (r_beat_cnt == LAST_IDX)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                writeback_done = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_state     <= ST_IDLE;
            r_rd_cnt    <= '0;
            r_beat_cnt  <= '0;
            r_last_addr <= '0;
            r_rd_vld    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_vld <= ren && w_in_rdy;
            if ((r_state == ST_IDLE) && chunk_done) begin
                r_rd_cnt   <= '0;
                r_beat_cnt <= '0;
            end else begin
                if (ren) begin
                    r_rd_cnt    <= r_rd_cnt + 1'b1;
                    r_last_addr <= r_rd_cnt[ADDRESS_WIDTH-1:0];
                end
                if (w_pop) r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_pixel_writeback.sv
// Directed bench for ddr_pixel_writeback with DEPTH=4 and a one-cycle-latency
// BRAM model; a negedge monitor scores every read, beat and done pulse.
module tb_ddr_pixel_writeback;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 12;
    localparam int TW    = 144;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          chunk_done = 1'b0;
    logic          tready = 1'b0;
    logic          ren;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] n_q = '0, null_q = '0, ne_q = '0, e_q = '0, se_q = '0;
    logic [DW-1:0] s_q = '0, sw_q = '0, w_q = '0, nw_q = '0;
    logic          tvalid;
    logic [TW-1:0] tdata;
    logic [17:0]   tstrb;
    logic          tlast;
    logic          busy;
    logic          wb_done;

    int n_pass = 0;
    int n_chk  = 0;
    int exp_rd = 0, exp_beat = 0, cyc = 0, first_hs = -1, last_hs = -1, wb_cnt = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    ddr_pixel_writeback #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .ADDRESS_WIDTH (AW), .C_M00_AXIS_TDATA_WIDTH (TW)
    ) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rstn),
        .chunk_done       (chunk_done),
        .ren              (ren),
        .read_addr        (read_addr),
        .n_q (n_q), .null_q (null_q), .ne_q (ne_q), .e_q (e_q), .se_q (se_q),
        .s_q (s_q), .sw_q (sw_q), .w_q (w_q), .nw_q (nw_q),
        .m00_axis_tvalid  (tvalid),
        .m00_axis_tready  (tready),
        .m00_axis_tdata   (tdata),
        .m00_axis_tstrb   (tstrb),
        .m00_axis_tlast   (tlast),
        .busy             (busy),
        .writeback_done   (wb_done)
    );

    // Pixel k: direction d holds 0x0100 + 9k + d; n in bits [15:0] ... nw in [143:128]
    function automatic logic [TW-1:0] pix(input int k);
        logic [TW-1:0] r;
        r = '0;
        for (int d = 0; d < 9; d++) r[d*16 +: 16] = 16'(32'h0100 + k*9 + d);
        return r;
    endfunction

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge clk) begin
        if (ren) begin
            logic [TW-1:0] p;
            p = pix(int'(read_addr));
            n_q <= p[15:0];    null_q <= p[31:16];  ne_q <= p[47:32];
            e_q <= p[63:48];   se_q   <= p[79:64];  s_q  <= p[95:80];
            sw_q <= p[111:96]; w_q    <= p[127:112]; nw_q <= p[143:128];
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rstn && mon_en) begin
            if (ren) begin
                check("rd_addr", TW'(read_addr), TW'(exp_rd));
                check("rd_outstanding",
                      TW'(((exp_rd + 1) - (exp_beat + int'(tvalid && tready))) <= 2), TW'(1));
                exp_rd++;
            end
            if (tvalid) begin
                check("tdata", tdata, pix(exp_beat));
                check("tlast", TW'(tlast), TW'(exp_beat == DEPTH-1));
                if (tready) begin
                    if (exp_beat == 0) first_hs = cyc;
                    last_hs = cyc;
                    exp_beat++;
                end
            end
            if (wb_done) begin
                wb_cnt++;
                check("wb_one_cycle_after_last", TW'(cyc - last_hs), TW'(1));
                check("wb_all_beats", TW'(exp_beat), TW'(DEPTH));
            end
        end
    end

    task automatic start_chunk();
        exp_rd = 0; exp_beat = 0; first_hs = -1; last_hs = -1;
        chunk_done = 1'b1;
        @(posedge clk); #1;
        chunk_done = 1'b0;
    endtask

    // mode 0: tready high; 1: tready toggles 1/0; 2: tready high plus a stray chunk_done
    task automatic run_until_done(input int mode, input int budget);
        int start_wb;
        bit done;
        start_wb = wb_cnt;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tready     = (mode == 1) ? (i % 2 == 0) : 1'b1;
            chunk_done = (mode == 2) && (i == 1);
            @(posedge clk); #1;
            if (wb_cnt != start_wb) done = 1'b1;
        end
        chunk_done = 1'b0;
        check("done_within_budget", TW'(done), TW'(1));
    endtask

    initial begin
        int beats_before;
        int prev_wb;
        #12;
        check("rst_ren", TW'(ren), TW'(0));
        check("rst_tvalid", TW'(tvalid), TW'(0));
        check("rst_tlast", TW'(tlast), TW'(0));
        check("rst_busy", TW'(busy), TW'(0));
        check("rst_wb_done", TW'(wb_done), TW'(0));
        check("rst_read_addr", TW'(read_addr), TW'(0));
        check("rst_tdata", tdata, TW'(0));
        check("rst_tstrb", TW'(tstrb), TW'(18'h3ffff));
        @(posedge clk); #1;
        rstn = 1'b1;
        mon_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Full-rate chunk
        tready = 1'b1;
        start_chunk();
        check("busy_after_start", TW'(busy), TW'(1));
        @(negedge clk); check("lat_cycle0_tvalid", TW'(tvalid), TW'(0));
        @(negedge clk); check("lat_cycle1_tvalid", TW'(tvalid), TW'(0));
        @(negedge clk); check("lat_cycle2_tvalid", TW'(tvalid), TW'(1));
        @(posedge clk); #1;
        run_until_done(0, 20);
        check("full_beats", TW'(exp_beat), TW'(DEPTH));
        check("full_consecutive", TW'(last_hs - first_hs), TW'(DEPTH-1));
        check("full_wb_cnt", TW'(wb_cnt), TW'(1));
        check("full_busy_low", TW'(busy), TW'(0));
        check("full_wb_single", TW'(wb_done), TW'(0));

        // tready toggling
        start_chunk();
        run_until_done(1, 40);
        check("toggle_beats", TW'(exp_beat), TW'(DEPTH));
        check("toggle_reads", TW'(exp_rd), TW'(DEPTH));
        check("toggle_wb_cnt", TW'(wb_cnt), TW'(2));

        // Long stall
        tready = 1'b0;
        start_chunk();
        repeat (20) begin @(posedge clk); #1; end
        check("stall_reads_le2", TW'(exp_rd <= 2), TW'(1));
        check("stall_tvalid", TW'(tvalid), TW'(1));
        check("stall_tdata_pix0", tdata, pix(0));
        check("stall_no_beats", TW'(exp_beat), TW'(0));
        run_until_done(0, 20);
        check("stall_drain_beats", TW'(exp_beat), TW'(DEPTH));

        // chunk_done re-pulsed mid-stream
        prev_wb = wb_cnt;
        start_chunk();
        run_until_done(2, 20);
        repeat (6) begin @(posedge clk); #1; end
        check("repulse_beats", TW'(exp_beat), TW'(DEPTH));
        check("repulse_single_wb", TW'(wb_cnt - prev_wb), TW'(1));
        check("repulse_idle", TW'(busy), TW'(0));

        // Reset mid-chunk, after two beats
        tready = 1'b1;
        start_chunk();
        for (int i = 0; i < 20 && exp_beat < 2; i++) begin @(posedge clk); #1; end
        check("mid_reached_beat2", TW'(exp_beat), TW'(2));
        rstn = 1'b0;
        #1;
        check("mid_rst_ren", TW'(ren), TW'(0));
        check("mid_rst_tvalid", TW'(tvalid), TW'(0));
        check("mid_rst_tlast", TW'(tlast), TW'(0));
        check("mid_rst_busy", TW'(busy), TW'(0));
        check("mid_rst_read_addr", TW'(read_addr), TW'(0));
        check("mid_rst_tdata", tdata, TW'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        beats_before = exp_beat;
        repeat (5) begin @(posedge clk); #1; end
        check("post_rst_no_beats", TW'(exp_beat), TW'(beats_before));
        check("post_rst_tvalid", TW'(tvalid), TW'(0));
        prev_wb = wb_cnt;
        start_chunk();
        run_until_done(0, 20);
        check("restart_beats", TW'(exp_beat), TW'(DEPTH));
        check("restart_wb", TW'(wb_cnt - prev_wb), TW'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
